hwpe_cmd_decoder: RTL and testbench
===================================

Name: hwpe_cmd_decoder

Overview:
- Device-side receiver for the HWPE custom-0 command stream. Each command is a 96-bit beat: instruction word, rs1 data, rs2 data.
- Decodes each instruction by one-hot funct7, then does one of: update the config/base-address/matrix registers, drive accumulator-register and ReLU requests into the PE array, or return accumulator values on a response channel.
- Sits between the host command interface and the conv engine, replacing the testbench command file in silicon.

Parameters:
- OPCODE, 7'b0001011, custom-0 opcode accepted; any other opcode is illegal.
- DW, 32, width of the rs1/rs2/response data.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- cmd_valid  in  1; cmd_ready  out  1: command handshake
- cmd_inst  in  32: instruction word. Fields: [31:25] funct7, [24:20] rs2, [19:15] rs1, [14:12] xd/xs1/xs2, [11:7] rd, [6:0] opcode
- cmd_rs1, cmd_rs2  in  DW: operand data
- resp_valid  out  1; resp_ready  in  1; resp_rd  out  5; resp_data  out  DW: response channel
- cfg_w_offset, cfg_ch_count  out  16 each
- cfg_k_count  out  10
- cfg_acc_shift  out  5
- cfg_k333, cfg_layer_type  out  1 each
- cfg_data_type  out  2
- cfg_ksize  out  4
- fmem_base  out  256: eight 32-bit base addresses; entry i occupies [32i+31:32i]
- mtx_h_count, mtx_w_count, mtx_h_stride, mtx_w_stride  out  16 each
- pe_start  out  1: pulse, start matrix run
- pe_done  in  1: pulse, run or tile finished
- tile_next  out  1: pulse, release engine to next output tile
- acc_we, acc_re  out  1 each
- acc_row  out  3; acc_pe  out  4; acc_wdata  out  DW
- acc_rvalid  in  1; acc_rdata  in  DW
- relu_req  out  1; relu_row  out  3; relu_addr  out  DW; relu_ack  in  1
- soft_rst  out  1: pulse
- busy  out  1: engine running
- illegal  out  1: sticky error flag

Behaviour:
- Reset: all registered outputs are 0. FSM goes to IDLE. illegal is cleared.
- FSM states: IDLE, RACC, RESP, RELU, RUN.
- cmd_ready = (state==IDLE). A command is accepted on cmd_valid & cmd_ready.
- Register updates and pulses take effect on the cycle after acceptance (1-cycle latency).
- funct7=64, reset:
  - Clears every cfg/fmem/mtx register to 0.
  - Pulses soft_rst. Stays in IDLE.
- funct7=2, wcfg:
  - {cfg_w_offset, cfg_ch_count} <= rs1 data [31:16], [15:0].
  - From rs2 data: cfg_k_count <= [22:13], cfg_acc_shift <= [12:8], cfg_k333 <= [7], cfg_layer_type <= [6], cfg_data_type <= [5:4], cfg_ksize <= [3:0].
  - rs2 data bits [31:23] are ignored.
- funct7=1, wfad:
  - idx = rd[2:0] & 3'b110.
  - base[idx] <= rs1 data; base[idx+1] <= rs2 data.
  - rd[0] and rd[4:3] are ignored.
- funct7=4, matrix:
  - {mtx_w_count, mtx_h_count} <= rs1 data; {mtx_w_stride, mtx_h_stride} <= rs2 data.
  - Pulses pe_start and goes to RUN.
- funct7=8, wacc: one-cycle acc_we with acc_row = rd[2:0], acc_pe = rs2 field[3:0], acc_wdata = rs1 data.
- funct7=16, racc:
  - Drives acc_re for one cycle with acc_row = rs1 field[2:0], acc_pe = rs2 field[3:0].
  - Goes to RACC and waits for acc_rvalid; acc_rdata is captured into resp_data, resp_rd <= rd.
  - Then RESP: resp_valid stays high until resp_ready, then back to IDLE.
  - Flag: rs1 field[4:3]==2'b10 marks last-of-tile.
- funct7=32, relu:
  - relu_req held with relu_row = rs2 field[2:0] and relu_addr = rs1 data, in state RELU, until relu_ack.
  - Flag: rs2 field[4:3]==2'b10 marks last-of-tile.
- Last-of-tile flag on racc or relu: when the op completes (resp handshake, or relu_ack), pulse tile_next and go to RUN instead of IDLE.
- RUN:
  - busy = 1 and cmd_ready = 0.
  - pe_done returns the FSM to IDLE on the next cycle.
  - If pe_done is coincident with the pe_start/tile_next pulse, it is ignored. RUN always lasts at least one cycle.
- Illegal commands: opcode != OPCODE, or funct7 not exactly one-hot among {1,2,4,8,16,32,64}.
  - The command is accepted and dropped, with no side effects.
  - illegal is set and stays set until rst or a reset command.
- Command with xd=1 other than racc: no response is generated. xd is not checked.
- acc_rvalid while not in RACC, or relu_ack while not in RELU: ignored.
- rst asserted mid-operation (any state): returns to IDLE next cycle. All pulses and requests deassert with no completion, and resp_valid drops.
- Only one command is in flight at a time.
- resp_data holds its value after the handshake until the next racc completes.

Test Plan:
- wcfg with rs1=0x0120_0003, rs2=0x0000_0871 -> cfg_w_offset=0x0120, cfg_ch_count=3, cfg_k_count=0, cfg_acc_shift=8, cfg_k333=0, cfg_layer_type=1, cfg_data_type=3, cfg_ksize=1.
- Four wfad commands (rd=0,2,4,6) with distinct data, then a wfad with rd=3 -> base[0..7] correct after the first four; the rd=3 command writes base[2]/base[3].
- matrix with rs1=0x0004_0002, then pe_done 5 cycles later -> pe_start pulses 1 cycle after acceptance; busy=1 and cmd_ready=0 until the cycle after pe_done.
- racc row=3 pe=7 with acc_rvalid 2 cycles later (data 0xDEAD_BEEF) and resp_ready low for 3 cycles -> resp_valid stable with resp_data=0xDEAD_BEEF, then the FSM returns to IDLE. Repeat with rs1 field=5'b10111 -> tile_next pulses after the handshake and the FSM enters RUN.
- relu with rs2 field=5'b10111 and rs1 data=128, relu_ack after 4 cycles -> relu_req held for 4 cycles with relu_row=7 and relu_addr=128, then tile_next pulses.
- Opcode 0x0B with funct7=3 -> illegal=1 and no register change; a following reset command clears illegal and all config, with soft_rst pulsing. rst during RESP drops resp_valid the next cycle.

Source files
------------

// File: rtl/hwpe_cmd_decoder.sv
// HWPE custom-0 command decoder: config/base/matrix registers, accumulator and ReLU requests, responses.
// Latency: register updates and pulses appear 1 cycle after acceptance; racc answers after acc_rvalid.
// Backpressure: cmd_ready only in IDLE; resp_valid held until resp_ready; relu_req held until relu_ack.
module hwpe_cmd_decoder #(
  parameter logic [6:0] OPCODE = 7'b0001011,
  parameter int         DW     = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [31:0]   cmd_inst,
  input  logic [DW-1:0] cmd_rs1,
  input  logic [DW-1:0] cmd_rs2,
  output logic          resp_valid,
  input  logic          resp_ready,
  output logic [4:0]    resp_rd,
  output logic [DW-1:0] resp_data,
  output logic [15:0]   cfg_w_offset,
  output logic [15:0]   cfg_ch_count,
  output logic [9:0]    cfg_k_count,
  output logic [4:0]    cfg_acc_shift,
  output logic          cfg_k333,
  output logic          cfg_layer_type,
  output logic [1:0]    cfg_data_type,
  output logic [3:0]    cfg_ksize,
  output logic [255:0]  fmem_base,
  output logic [15:0]   mtx_h_count,
  output logic [15:0]   mtx_w_count,
  output logic [15:0]   mtx_h_stride,
  output logic [15:0]   mtx_w_stride,
  output logic          pe_start,
  input  logic          pe_done,
  output logic          tile_next,
  output logic          acc_we,
  output logic          acc_re,
  output logic [2:0]    acc_row,
  output logic [3:0]    acc_pe,
  output logic [DW-1:0] acc_wdata,
  input  logic          acc_rvalid,
  input  logic [DW-1:0] acc_rdata,
  output logic          relu_req,
  output logic [2:0]    relu_row,
  output logic [DW-1:0] relu_addr,
  input  logic          relu_ack,
  output logic          soft_rst,
  output logic          busy,
  output logic          illegal
);

  typedef enum logic [2:0] {S_IDLE, S_RACC, S_RESP, S_RELU, S_RUN} state_t;

  state_t        r_state;
  state_t        w_state_nxt;

  // Instruction fields
  logic [6:0]    w_funct7;
  logic [4:0]    w_rs2f;
  logic [4:0]    w_rs1f;
  logic [4:0]    w_rd;
  logic [6:0]    w_opc;
  logic          w_accept;
  logic          w_onehot;
  logic          w_legal;
  logic          w_do_wfad, w_do_wcfg, w_do_mtx, w_do_wacc, w_do_racc, w_do_relu, w_do_reset;
  logic          w_bad_cmd;
  logic          w_op_done;
  logic          w_unused_xd;

  // Architectural registers
  logic [15:0]   r_cfg_w_offset, r_cfg_ch_count;
  logic [9:0]    r_cfg_k_count;
  logic [4:0]    r_cfg_acc_shift;
  logic          r_cfg_k333, r_cfg_layer_type;
  logic [1:0]    r_cfg_data_type;
  logic [3:0]    r_cfg_ksize;
  logic [31:0]   r_base [8];
  logic [15:0]   r_mtx_h_count, r_mtx_w_count, r_mtx_h_stride, r_mtx_w_stride;

  // Pulses, request payloads and response state
  logic          r_pe_start, r_tile_next, r_acc_we, r_acc_re, r_soft_rst, r_illegal;
  logic [2:0]    r_acc_row;
  logic [3:0]    r_acc_pe;
  logic [DW-1:0] r_acc_wdata;
  logic [2:0]    r_relu_row;
  logic [DW-1:0] r_relu_addr;
  logic          r_last;
  logic [4:0]    r_pend_rd;
  logic [4:0]    r_resp_rd;
  logic [DW-1:0] r_resp_data;

  assign w_funct7    = cmd_inst[31:25];
  assign w_rs2f      = cmd_inst[24:20];
  assign w_rs1f      = cmd_inst[19:15];
  assign w_rd        = cmd_inst[11:7];
  assign w_opc       = cmd_inst[6:0];
  // xd/xs1/xs2 carry no meaning here: only racc ever answers
  assign w_unused_xd = ^cmd_inst[14:12];

  assign w_accept   = cmd_valid & cmd_ready;
  assign w_onehot   = (w_funct7 != 7'd0) && ((w_funct7 & (w_funct7 - 7'd1)) == 7'd0);
  assign w_legal    = (w_opc == OPCODE) && w_onehot;
  assign w_do_wfad  = w_accept & w_legal & w_funct7[0];
  assign w_do_wcfg  = w_accept & w_legal & w_funct7[1];
  assign w_do_mtx   = w_accept & w_legal & w_funct7[2];
  assign w_do_wacc  = w_accept & w_legal & w_funct7[3];
  assign w_do_racc  = w_accept & w_legal & w_funct7[4];
  assign w_do_relu  = w_accept & w_legal & w_funct7[5];
  assign w_do_reset = w_accept & w_legal & w_funct7[6];
  assign w_bad_cmd  = w_accept & ~w_legal;

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state and state-decoded outputs
  always_comb begin
    w_state_nxt = r_state;
    cmd_ready   = 1'b0;
    busy        = 1'b0;
    resp_valid  = 1'b0;
    relu_req    = 1'b0;
    w_op_done   = 1'b0;
    case (r_state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (w_do_mtx)       w_state_nxt = S_RUN;
        else if (w_do_racc) w_state_nxt = S_RACC;
        else if (w_do_relu) w_state_nxt = S_RELU;
      end
      S_RACC: begin
        if (acc_rvalid) w_state_nxt = S_RESP;
      end
      S_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          w_op_done   = 1'b1;
          w_state_nxt = r_last ? S_RUN : S_IDLE;
        end
      end
      S_RELU: begin
        relu_req = 1'b1;
        if (relu_ack) begin
          w_op_done   = 1'b1;
          w_state_nxt = r_last ? S_RUN : S_IDLE;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        // A done arriving with the start/tile_next pulse belongs to the previous run
        if (pe_done && !r_pe_start && !r_tile_next) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Config, base-address and matrix registers; reset command wipes them
  always_ff @(posedge clk) begin
    if (rst || w_do_reset) begin
      r_cfg_w_offset   <= '0;
      r_cfg_ch_count   <= '0;
      r_cfg_k_count    <= '0;
      r_cfg_acc_shift  <= '0;
      r_cfg_k333       <= 1'b0;
      r_cfg_layer_type <= 1'b0;
      r_cfg_data_type  <= '0;
      r_cfg_ksize      <= '0;
      for (int i = 0; i < 8; i++) r_base[i] <= '0;
      r_mtx_h_count    <= '0;
      r_mtx_w_count    <= '0;
      r_mtx_h_stride   <= '0;
      r_mtx_w_stride   <= '0;
    end else begin
      if (w_do_wcfg) begin
        r_cfg_w_offset   <= cmd_rs1[31:16];
        r_cfg_ch_count   <= cmd_rs1[15:0];
        r_cfg_k_count    <= cmd_rs2[22:13];
        r_cfg_acc_shift  <= cmd_rs2[12:8];
        r_cfg_k333       <= cmd_rs2[7];
        r_cfg_layer_type <= cmd_rs2[6];
        r_cfg_data_type  <= cmd_rs2[5:4];
        r_cfg_ksize      <= cmd_rs2[3:0];
      end
      if (w_do_wfad) begin
        // Bases are written in even/odd pairs; rd[0] is forced low
        r_base[{w_rd[2:1], 1'b0}] <= cmd_rs1[31:0];
        r_base[{w_rd[2:1], 1'b1}] <= cmd_rs2[31:0];
      end
      if (w_do_mtx) begin
        {r_mtx_w_count, r_mtx_h_count}   <= cmd_rs1[31:0];
        {r_mtx_w_stride, r_mtx_h_stride} <= cmd_rs2[31:0];
      end
    end
  end

  // Pulses, accumulator/ReLU request payloads, response capture and error flag
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pe_start  <= 1'b0;
      r_tile_next <= 1'b0;
      r_acc_we    <= 1'b0;
      r_acc_re    <= 1'b0;
      r_soft_rst  <= 1'b0;
      r_illegal   <= 1'b0;
      r_acc_row   <= '0;
      r_acc_pe    <= '0;
      r_acc_wdata <= '0;
      r_relu_row  <= '0;
      r_relu_addr <= '0;
      r_last      <= 1'b0;
      r_pend_rd   <= '0;
      r_resp_rd   <= '0;
      r_resp_data <= '0;
    end else begin
      r_pe_start  <= w_do_mtx;
      r_acc_we    <= w_do_wacc;
      r_acc_re    <= w_do_racc;
      r_soft_rst  <= w_do_reset;
      r_tile_next <= w_op_done & r_last;
      if (w_do_reset)     r_illegal <= 1'b0;
      else if (w_bad_cmd) r_illegal <= 1'b1;
      if (w_do_wacc) begin
        r_acc_row   <= w_rd[2:0];
        r_acc_pe    <= w_rs2f[3:0];
        r_acc_wdata <= cmd_rs1;
      end
      if (w_do_racc) begin
        r_acc_row <= w_rs1f[2:0];
        r_acc_pe  <= w_rs2f[3:0];
        r_pend_rd <= w_rd;
        r_last    <= (w_rs1f[4:3] == 2'b10);
      end
      if (w_do_relu) begin
        r_relu_row  <= w_rs2f[2:0];
        r_relu_addr <= cmd_rs1;
        r_last      <= (w_rs2f[4:3] == 2'b10);
      end
      if (r_state == S_RACC && acc_rvalid) begin
        r_resp_data <= acc_rdata;
        r_resp_rd   <= r_pend_rd;
      end
    end
  end

  // Flatten base-address array onto the output bus
  always_comb begin
    fmem_base = '0;
    for (int i = 0; i < 8; i++) fmem_base[32*i +: 32] = r_base[i];
  end

  assign cfg_w_offset   = r_cfg_w_offset;
  assign cfg_ch_count   = r_cfg_ch_count;
  assign cfg_k_count    = r_cfg_k_count;
  assign cfg_acc_shift  = r_cfg_acc_shift;
  assign cfg_k333       = r_cfg_k333;
  assign cfg_layer_type = r_cfg_layer_type;
  assign cfg_data_type  = r_cfg_data_type;
  assign cfg_ksize      = r_cfg_ksize;
  assign mtx_h_count    = r_mtx_h_count;
  assign mtx_w_count    = r_mtx_w_count;
  assign mtx_h_stride   = r_mtx_h_stride;
  assign mtx_w_stride   = r_mtx_w_stride;
  assign pe_start       = r_pe_start;
  assign tile_next      = r_tile_next;
  assign acc_we         = r_acc_we;
  assign acc_re         = r_acc_re;
  assign acc_row        = r_acc_row;
  assign acc_pe         = r_acc_pe;
  assign acc_wdata      = r_acc_wdata;
  assign relu_row       = r_relu_row;
  assign relu_addr      = r_relu_addr;
  assign soft_rst       = r_soft_rst;
  assign illegal        = r_illegal;
  assign resp_rd        = r_resp_rd;
  assign resp_data      = r_resp_data;

endmodule

// File: tb/tb_hwpe_cmd_decoder.sv
// Testbench for hwpe_cmd_decoder: table of register-write/illegal vectors plus handshake sequences.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
// Responses are checked against a queue of expected {rd, data} pushed when each racc is issued.
module tb_hwpe_cmd_decoder;

  localparam logic [6:0] OPC = 7'h0B;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [31:0]  cmd_inst = '0, cmd_rs1 = '0, cmd_rs2 = '0;
  logic         resp_valid, resp_ready = 1'b0;
  logic [4:0]   resp_rd;
  logic [31:0]  resp_data;
  logic [15:0]  cfg_w_offset, cfg_ch_count;
  logic [9:0]   cfg_k_count;
  logic [4:0]   cfg_acc_shift;
  logic         cfg_k333, cfg_layer_type;
  logic [1:0]   cfg_data_type;
  logic [3:0]   cfg_ksize;
  logic [255:0] fmem_base;
  logic [15:0]  mtx_h_count, mtx_w_count, mtx_h_stride, mtx_w_stride;
  logic         pe_start, pe_done = 1'b0, tile_next;
  logic         acc_we, acc_re;
  logic [2:0]   acc_row;
  logic [3:0]   acc_pe;
  logic [31:0]  acc_wdata;
  logic         acc_rvalid = 1'b0;
  logic [31:0]  acc_rdata = '0;
  logic         relu_req;
  logic [2:0]   relu_row;
  logic [31:0]  relu_addr;
  logic         relu_ack = 1'b0;
  logic         soft_rst, busy, illegal;

  hwpe_cmd_decoder dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_inst(cmd_inst),
    .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rd(resp_rd), .resp_data(resp_data), .cfg_w_offset(cfg_w_offset), .cfg_ch_count(cfg_ch_count),
    .cfg_k_count(cfg_k_count), .cfg_acc_shift(cfg_acc_shift), .cfg_k333(cfg_k333),
    .cfg_layer_type(cfg_layer_type), .cfg_data_type(cfg_data_type), .cfg_ksize(cfg_ksize),
    .fmem_base(fmem_base), .mtx_h_count(mtx_h_count), .mtx_w_count(mtx_w_count),
    .mtx_h_stride(mtx_h_stride), .mtx_w_stride(mtx_w_stride), .pe_start(pe_start), .pe_done(pe_done),
    .tile_next(tile_next), .acc_we(acc_we), .acc_re(acc_re), .acc_row(acc_row), .acc_pe(acc_pe),
    .acc_wdata(acc_wdata), .acc_rvalid(acc_rvalid), .acc_rdata(acc_rdata), .relu_req(relu_req),
    .relu_row(relu_row), .relu_addr(relu_addr), .relu_ack(relu_ack), .soft_rst(soft_rst),
    .busy(busy), .illegal(illegal)
  );

  always #5 clk = ~clk;

  logic [54:0] w_cfg;
  logic [63:0] w_mtx;
  assign w_cfg = {cfg_w_offset, cfg_ch_count, cfg_k_count, cfg_acc_shift,
                  cfg_k333, cfg_layer_type, cfg_data_type, cfg_ksize};
  assign w_mtx = {mtx_w_stride, mtx_h_stride, mtx_w_count, mtx_h_count};

  int n_vec = 0;
  int n_err = 0;
  logic [36:0] sb_q[$];

  typedef struct {
    logic [31:0]  inst;
    logic [31:0]  rs1;
    logic [31:0]  rs2;
    logic [54:0]  cfg;
    logic [255:0] fmem;
    logic         ill;
  } vec_t;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [6:0] f7, input logic [4:0] rs2f, input logic [4:0] rs1f,
                                     input logic [2:0] x, input logic [4:0] rd, input logic [6:0] opc);
    return {f7, rs2f, rs1f, x, rd, opc};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [31:0] inst, input logic [31:0] rs1, input logic [31:0] rs2);
    int n = 0;
    while (!cmd_ready && n < 200) begin
      tick();
      n++;
    end
    if (!cmd_ready) begin
      n_vec++;
      n_err++;
      $display("FAIL cmd_ready_timeout: cmd_ready=%0b required 1", cmd_ready);
    end else begin
      cmd_inst  = inst;
      cmd_rs1   = rs1;
      cmd_rs2   = rs2;
      cmd_valid = 1'b1;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
    end
  endtask

  // Release the engine from RUN with a single pe_done pulse
  task automatic end_run();
    tick();
    pe_done = 1'b1;
    tick();
    pe_done = 1'b0;
    @(negedge clk);
    chk("run_exit_busy", busy, 1'b0);
    chk("run_exit_ready", cmd_ready, 1'b1);
  endtask

  // racc: acc_rvalid one cycle after acc_re, resp_ready held low for 3 cycles of RESP
  task automatic run_racc(input logic [4:0] rs1f, input logic [4:0] rs2f, input logic [4:0] rd,
                          input logic [31:0] data, input bit last);
    sb_q.push_back({rd, data});
    send_cmd(mk(7'd16, rs2f, rs1f, 3'b100, rd, OPC), $urandom, $urandom);
    @(negedge clk);
    chk("racc_re", acc_re, 1'b1);
    chk("racc_row", acc_row, rs1f[2:0]);
    chk("racc_pe", acc_pe, rs2f[3:0]);
    tick();
    acc_rvalid = 1'b1;
    acc_rdata  = data;
    @(negedge clk);
    chk("racc_re_drop", acc_re, 1'b0);
    chk("racc_no_resp_yet", resp_valid, 1'b0);
    tick();
    acc_rvalid = 1'b0;
    acc_rdata  = 32'h0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("resp_valid_hold", resp_valid, 1'b1);
      tick();
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    if (last) pe_done = 1'b1;
    @(negedge clk);
    chk("racc_resp_drop", resp_valid, 1'b0);
    chk("racc_tile_next", tile_next, last);
    chk("racc_busy", busy, last);
    if (last) begin
      tick();
      pe_done = 1'b0;
      @(negedge clk);
      chk("tile_coincident_done_ignored", busy, 1'b1);
      end_run();
    end
  endtask

  // Response scoreboard: every cycle resp_valid is up, data/rd must match the oldest expectation
  always @(negedge clk) begin
    if (!rst && resp_valid) begin
      if (sb_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL resp_unexpected: got rd=%0d data=%h, no response required", resp_rd, resp_data);
      end else begin
        chk("sb_resp_data", resp_data, sb_q[0][31:0]);
        chk("sb_resp_rd", resp_rd, sb_q[0][36:32]);
        if (resp_ready) void'(sb_q.pop_front());
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not reach the end, required completion");
    $fatal(1);
  end

  initial begin
    vec_t tbl[11];
    logic [54:0]  c0, c8;
    logic [255:0] f4, f5;
    c0 = {16'h0120, 16'h0003, 10'd0, 5'd8, 1'b0, 1'b1, 2'd3, 4'd1};
    c8 = {16'hBEEF, 16'h0010, 10'h3FF, 5'h1F, 1'b1, 1'b0, 2'd2, 4'hA};
    f4 = {32'h40000007, 32'h40000006, 32'h30000005, 32'h30000004,
          32'h20000003, 32'h20000002, 32'h10000001, 32'h10000000};
    f5 = {32'h40000007, 32'h40000006, 32'h30000005, 32'h30000004,
          32'hAAAA0003, 32'hAAAA0002, 32'h10000001, 32'h10000000};
    tbl[0]  = '{mk(7'd2, 5'd0, 5'd0, 3'b000, 5'd0, OPC), 32'h01200003, 32'h00000871, c0, 256'd0, 1'b0};
    tbl[1]  = '{mk(7'd1, 5'd0, 5'd0, 3'b000, 5'd0, OPC), 32'h10000000, 32'h10000001, c0,
                {192'd0, 32'h10000001, 32'h10000000}, 1'b0};
    tbl[2]  = '{mk(7'd1, 5'd0, 5'd0, 3'b000, 5'd2, OPC), 32'h20000002, 32'h20000003, c0,
                {128'd0, f4[127:0]}, 1'b0};
    tbl[3]  = '{mk(7'd1, 5'd0, 5'd0, 3'b000, 5'd4, OPC), 32'h30000004, 32'h30000005, c0,
                {64'd0, f4[191:0]}, 1'b0};
    tbl[4]  = '{mk(7'd1, 5'd0, 5'd0, 3'b000, 5'b11110, OPC), 32'h40000006, 32'h40000007, c0, f4, 1'b0};
    tbl[5]  = '{mk(7'd1, 5'd0, 5'd0, 3'b000, 5'd3, OPC), 32'hAAAA0002, 32'hAAAA0003, c0, f5, 1'b0};
    tbl[6]  = '{mk(7'd3, 5'd0, 5'd0, 3'b000, 5'd0, OPC), 32'hFFFFFFFF, 32'hFFFFFFFF, c0, f5, 1'b1};
    tbl[7]  = '{mk(7'd2, 5'd0, 5'd0, 3'b000, 5'd0, 7'h33), 32'hFFFFFFFF, 32'hFFFFFFFF, c0, f5, 1'b1};
    tbl[8]  = '{mk(7'd0, 5'd0, 5'd0, 3'b000, 5'd0, OPC), 32'hFFFFFFFF, 32'hFFFFFFFF, c0, f5, 1'b1};
    tbl[9]  = '{mk(7'h0C, 5'd0, 5'd0, 3'b000, 5'd0, OPC), 32'hFFFFFFFF, 32'hFFFFFFFF, c0, f5, 1'b1};
    tbl[10] = '{mk(7'd2, 5'd0, 5'd0, 3'b111, 5'd5, OPC), 32'hBEEF0010, 32'hFFFFFFAA, c8, f5, 1'b1};

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_illegal", illegal, 1'b0);
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_cfg", w_cfg, 55'd0);
    chk("rst_fmem", fmem_base, 256'd0);
    chk("rst_pulses", {pe_start, tile_next, acc_we, acc_re, relu_req, soft_rst}, 6'd0);

    // Register writes and illegal commands
    for (int i = 0; i < 11; i++) begin
      send_cmd(tbl[i].inst, tbl[i].rs1, tbl[i].rs2);
      @(negedge clk);
      chk($sformatf("vec%0d_cfg", i), w_cfg, tbl[i].cfg);
      chk($sformatf("vec%0d_fmem", i), fmem_base, tbl[i].fmem);
      chk($sformatf("vec%0d_illegal", i), illegal, tbl[i].ill);
      chk($sformatf("vec%0d_side", i), {busy, acc_we, pe_start, resp_valid, cmd_ready}, 5'b00001);
    end

    // wacc: one-cycle write strobe
    send_cmd(mk(7'd8, 5'b01010, 5'd0, 3'b000, 5'd5, OPC), 32'hCAFEF00D, 32'h0);
    @(negedge clk);
    chk("wacc_we", acc_we, 1'b1);
    chk("wacc_row_pe", {acc_row, acc_pe}, {3'd5, 4'd10});
    chk("wacc_wdata", acc_wdata, 32'hCAFEF00D);
    @(negedge clk);
    chk("wacc_we_drop", acc_we, 1'b0);

    // racc without last-of-tile
    run_racc(5'd3, 5'd7, 5'd9, 32'hDEADBEEF, 1'b0);

    // Stray acc_rvalid / relu_ack in IDLE are ignored and resp_data holds
    tick();
    acc_rvalid = 1'b1;
    acc_rdata  = 32'h55555555;
    relu_ack   = 1'b1;
    tick();
    acc_rvalid = 1'b0;
    relu_ack   = 1'b0;
    @(negedge clk);
    chk("stray_resp_data_hold", resp_data, 32'hDEADBEEF);
    chk("stray_state", {resp_valid, busy, tile_next, cmd_ready}, 4'b0001);

    // racc with last-of-tile: tile_next and RUN after the handshake
    run_racc(5'b10111, 5'd2, 5'd4, 32'h12345678, 1'b1);

    // matrix: pe_start pulse, done coincident with start ignored, done 5 cycles later ends RUN
    send_cmd(mk(7'd4, 5'd0, 5'd0, 3'b000, 5'd0, OPC), 32'h00040002, 32'h00030001);
    pe_done = 1'b1;
    @(negedge clk);
    chk("mtx_pe_start", pe_start, 1'b1);
    chk("mtx_regs", w_mtx, {16'h0003, 16'h0001, 16'h0004, 16'h0002});
    chk("mtx_busy0", {busy, cmd_ready}, 2'b10);
    tick();
    pe_done = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      chk($sformatf("mtx_busy%0d", i), {busy, cmd_ready, pe_start}, 3'b100);
      tick();
      if (i == 3) pe_done = 1'b1;
      if (i == 4) pe_done = 1'b0;
    end
    @(negedge clk);
    chk("mtx_done_idle", {busy, cmd_ready}, 2'b01);

    // relu with last-of-tile, ack after 4 cycles of request
    send_cmd(mk(7'd32, 5'b10111, 5'd0, 3'b000, 5'd0, OPC), 32'd128, 32'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("relu_req%0d", i), {relu_req, relu_row}, {1'b1, 3'd7});
      chk($sformatf("relu_addr%0d", i), relu_addr, 32'd128);
      tick();
      if (i == 2) relu_ack = 1'b1;
      if (i == 3) relu_ack = 1'b0;
    end
    @(negedge clk);
    chk("relu_done", {relu_req, tile_next, busy}, 3'b011);
    end_run();

    // Reset command clears illegal and every cfg/fmem/mtx register
    chk("illegal_sticky", illegal, 1'b1);
    send_cmd(mk(7'd64, 5'd0, 5'd0, 3'b000, 5'd0, OPC), 32'hFFFFFFFF, 32'hFFFFFFFF);
    @(negedge clk);
    chk("rstcmd_soft_rst", soft_rst, 1'b1);
    chk("rstcmd_illegal", illegal, 1'b0);
    chk("rstcmd_cfg", w_cfg, 55'd0);
    chk("rstcmd_fmem", fmem_base, 256'd0);
    chk("rstcmd_mtx", w_mtx, 64'd0);
    chk("rstcmd_idle", {busy, cmd_ready}, 2'b01);
    @(negedge clk);
    chk("rstcmd_soft_rst_drop", soft_rst, 1'b0);

    // rst while in RESP drops resp_valid next cycle
    sb_q.push_back({5'd1, 32'h0BADCAFE});
    send_cmd(mk(7'd16, 5'd0, 5'd0, 3'b100, 5'd1, OPC), 32'h0, 32'h0);
    acc_rvalid = 1'b1;
    acc_rdata  = 32'h0BADCAFE;
    tick();
    acc_rvalid = 1'b0;
    @(negedge clk);
    chk("rstresp_valid", resp_valid, 1'b1);
    tick();
    rst = 1'b1;
    tick();
    @(negedge clk);
    chk("rstresp_drop", {resp_valid, busy, cmd_ready}, 3'b001);
    rst = 1'b0;
    sb_q.delete();

    chk("sb_empty", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
